// File: rtl/fir_controller.sv
// fir_controller: sequencing FSM for the 4-tap FIR datapath.
// Loads coefficients on request, and for each new sample shifts the
// history, stores the sample and runs the multiply-accumulate chain
// into R0. Busy/error status is registered for the status register.
module fir_controller #(
    parameter logic [3:0] SAMPLE_BASE = 4'd1,
    parameter logic [3:0] COEFF_BASE  = 4'd5,
    parameter logic [3:0] TMP_REG     = 4'd9
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       data_ready,
    input  logic       new_coefficient_set,
    input  logic       overflow,
    output logic       cnt_up,
    output logic       clear_coeff,
    output logic [1:0] coefficient_num,
    output logic       modwait,
    output logic       err,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest
);

    localparam logic [2:0] OP_NOP         = 3'd0;
    localparam logic [2:0] OP_COPY        = 3'd1;
    localparam logic [2:0] OP_LOAD_SAMPLE = 3'd2;
    localparam logic [2:0] OP_LOAD_COEFF  = 3'd3;
    localparam logic [2:0] OP_ADD         = 3'd4;
    localparam logic [2:0] OP_SUB         = 3'd5;
    localparam logic [2:0] OP_MUL         = 3'd6;

    localparam logic [3:0] ACC_REG = 4'd0;

    typedef enum logic [4:0] {
        IDLE, LC0, LC1, LC2, LC3, CLRC,
        SH4, SH3, SH2, STORE, ZERO,
        MUL0, ADD0, MUL1, ADD1, MUL2, ADD2, MUL3, ADD3,
        EIDLE
    } state_t;

    state_t state;
    state_t next_state;

    // State register plus busy/error flags decoded from the next state so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            modwait <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= next_state;
            modwait <= !((next_state == IDLE) || (next_state == EIDLE));
            err     <= (next_state == EIDLE);
        end
    end

    // Next-state logic; a new sample always wins over a coefficient reload.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, EIDLE: begin
                if (data_ready)
                    next_state = SH4;
                else if (new_coefficient_set)
                    next_state = LC0;
            end
            LC0:   next_state = LC1;
            LC1:   next_state = LC2;
            LC2:   next_state = LC3;
            LC3:   next_state = CLRC;
            CLRC:  next_state = IDLE;
            SH4:   next_state = SH3;
            SH3:   next_state = SH2;
            SH2:   next_state = STORE;
            STORE: next_state = data_ready ? ZERO : EIDLE;
            ZERO:  next_state = MUL0;
            MUL0:  next_state = ADD0;
            ADD0:  next_state = overflow ? EIDLE : MUL1;
            MUL1:  next_state = ADD1;
            ADD1:  next_state = overflow ? EIDLE : MUL2;
            MUL2:  next_state = ADD2;
            ADD2:  next_state = overflow ? EIDLE : MUL3;
            MUL3:  next_state = ADD3;
            ADD3:  next_state = overflow ? EIDLE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath command decode from the current state; unused fields stay 0.
    always_comb begin
        op              = OP_NOP;
        src1            = 4'd0;
        src2            = 4'd0;
        dest            = 4'd0;
        coefficient_num = 2'd0;
        cnt_up          = 1'b0;
        clear_coeff     = 1'b0;
        case (state)
            LC0: begin op = OP_LOAD_COEFF; dest = COEFF_BASE;         coefficient_num = 2'd0; end
            LC1: begin op = OP_LOAD_COEFF; dest = COEFF_BASE + 4'd1;  coefficient_num = 2'd1; end
            LC2: begin op = OP_LOAD_COEFF; dest = COEFF_BASE + 4'd2;  coefficient_num = 2'd2; end
            LC3: begin op = OP_LOAD_COEFF; dest = COEFF_BASE + 4'd3;  coefficient_num = 2'd3; end
            CLRC: clear_coeff = 1'b1;
            SH4: begin op = OP_COPY; src1 = SAMPLE_BASE + 4'd2; dest = SAMPLE_BASE + 4'd3; end
            SH3: begin op = OP_COPY; src1 = SAMPLE_BASE + 4'd1; dest = SAMPLE_BASE + 4'd2; end
            SH2: begin op = OP_COPY; src1 = SAMPLE_BASE;        dest = SAMPLE_BASE + 4'd1; end
            STORE: begin
                if (data_ready) begin
                    op     = OP_LOAD_SAMPLE;
                    dest   = SAMPLE_BASE;
                    cnt_up = 1'b1;
                end
            end
            ZERO: begin op = OP_SUB; src1 = ACC_REG; src2 = ACC_REG; dest = ACC_REG; end
            MUL0: begin op = OP_MUL; src1 = SAMPLE_BASE;        src2 = COEFF_BASE;        dest = TMP_REG; end
            MUL1: begin op = OP_MUL; src1 = SAMPLE_BASE + 4'd1; src2 = COEFF_BASE + 4'd1; dest = TMP_REG; end
            MUL2: begin op = OP_MUL; src1 = SAMPLE_BASE + 4'd2; src2 = COEFF_BASE + 4'd2; dest = TMP_REG; end
            MUL3: begin op = OP_MUL; src1 = SAMPLE_BASE + 4'd3; src2 = COEFF_BASE + 4'd3; dest = TMP_REG; end
            ADD0, ADD1, ADD2, ADD3: begin
                op   = OP_ADD;
                src1 = ACC_REG;
                src2 = TMP_REG;
                dest = ACC_REG;
            end
            default: ;
        endcase
    end

endmodule
